stopwatch_timer_core: RTL and testbench
=======================================

Name: stopwatch_timer_core

Overview:
Timekeeping core of the stopwatch, directly upstream of the seven-segment display driver.
- Divides the board clock into a 1 Hz time base.
- Runs a start/pause/clear state machine.
- Presents binary minutes (0–99) and seconds (0–59) as 7-bit values for the display driver to split into digits.
- Inputs are single-cycle pulses from the button debouncer stage.

Parameters:
TICKS_PER_SEC, 50000000, clock cycles per counted second. Benches override to 4.
PRESC_W, 26, prescaler width. Must satisfy 2**PRESC_W >= TICKS_PER_SEC.
MAX_MINUTES, 99, last minute value before wrap. Must be <= 127.

Ports:
clock  input  1  board clock
reset  input  1  asynchronous, active-high reset
start_stop  input  1  one-cycle pulse; toggles run/pause
clear  input  1  one-cycle pulse; returns to 00:00 idle
lap  input  1  one-cycle pulse; lap hold toggle (used only with LAP_HOLD_EN)
minutes  output  7  displayed minutes, binary, 0..MAX_MINUTES
seconds  output  7  displayed seconds, binary, 0..59
running  output  1  high while in RUNNING
rollover  output  1  one-cycle pulse on wrap from MAX_MINUTES:59 to 00:00
hold_active  output  1  high while lap hold is engaged

Behaviour:
- Reset: reset, asynchronous, active-high; clock clock.
  - During reset: state=IDLE, prescaler=0, internal min/sec=0.
  - Output reset values: minutes=0, seconds=0, running=0, rollover=0, hold_active=0.
- All outputs are registered. No combinational path from inputs to outputs.
- States:
  - IDLE: time 00:00, prescaler 0.
  - RUNNING: counting.
  - PAUSED: time and prescaler frozen.
- Transitions (sampled on rising edge):
  - IDLE + start_stop -> RUNNING.
  - RUNNING + start_stop -> PAUSED.
  - PAUSED + start_stop -> RUNNING.
  - Any state + clear -> IDLE, zeroing time and prescaler.
  - clear has priority over start_stop and lap in the same cycle.
- running is asserted from the edge that enters RUNNING. It is deasserted from the edge that leaves it.
- Prescaler:
  - Increments every cycle in RUNNING.
  - When it equals TICKS_PER_SEC-1 in RUNNING, the next edge sets it to 0 and advances time by one second.
  - From IDLE, the first increment is visible exactly TICKS_PER_SEC edges after the start_stop edge.
  - PAUSED holds the prescaler, so the partial second is preserved across pause/resume.
- Time advance:
  - seconds 0..58 -> +1.
  - seconds 59 -> 0 and minutes +1.
  - MAX_MINUTES:59 -> 00:00, rollover high for exactly that one cycle. Stays RUNNING.
- start_stop arriving on the same edge as a second tick:
  - The tick is applied.
  - The state still toggles to PAUSED.
- Mid-operation reset behaves identically to power-on reset.

Optional Feature:
LAP_HOLD_EN
- Defined:
  - In RUNNING, a lap pulse freezes minutes/seconds outputs at their current values and sets hold_active=1.
  - Internal time keeps counting during the hold.
  - The next lap pulse releases the hold. Outputs show live time on the following edge.
  - clear releases the hold.
  - Pause/resume does not release the hold.
  - lap in IDLE or PAUSED with no hold engaged is ignored.
  - lap in PAUSED with hold engaged releases the hold.
  - rollover still pulses from internal time.
- Undefined:
  - lap is ignored; hold_active is tied 0.
  - Outputs always show live time.

Test Plan:
- reset mid-count at 00:07 -> minutes=0, seconds=0, running=0 immediately (asynchronous); after release, state IDLE.
- TICKS_PER_SEC=4; start_stop at edge N -> running=1 after N; seconds=1 after edge N+4; seconds=2 after edge N+8.
- Pause 2 cycles into a second, wait 20 cycles, resume -> seconds unchanged during pause; next increment 2 cycles after the resume edge.
- Preload run to 00:59, one more tick -> 01:00. Run to 99:59, one more tick -> 00:00, rollover high exactly 1 cycle, running stays 1.
- clear and start_stop in the same cycle while RUNNING at 03:15 -> 00:00, state IDLE, running=0.
- LAP_HOLD_EN defined:
  - lap at 00:05 -> outputs hold 00:05, hold_active=1, while internal time reaches 00:09.
  - Second lap -> outputs 00:09 next edge, hold_active=0.
- LAP_HOLD_EN undefined: same lap stimulus -> outputs track live time, hold_active=0 throughout.

Source files
------------

// File: rtl/stopwatch_timer_core.sv
// Stopwatch timekeeping: 1 Hz prescaler, start/pause/clear FSM, binary mm:ss to the display driver.
// Optional lap hold (freeze displayed time while counting continues) enabled by defining LAP_HOLD_EN.
module stopwatch_timer_core #(
  parameter int TICKS_PER_SEC = 50000000,
  parameter int PRESC_W       = 26,
  parameter int MAX_MINUTES   = 99
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start_stop,
  input  logic       clear,
  input  logic       lap,
  output logic [6:0] minutes,
  output logic [6:0] seconds,
  output logic       running,
  output logic       rollover,
  output logic       hold_active
);

  typedef enum logic [1:0] {IDLE, RUNNING, PAUSED} state_t;

  state_t             state, state_nxt;
  logic [PRESC_W-1:0] presc, presc_nxt;
  logic [6:0]         min_r, sec_r, min_nxt, sec_nxt;
  logic               tick, wrap, hold_nxt;

  always_comb begin
    state_nxt = state;
    presc_nxt = presc;
    min_nxt   = min_r;
    sec_nxt   = sec_r;
    tick      = 1'b0;
    wrap      = 1'b0;

    if (state == RUNNING) begin
      if (presc == PRESC_W'(TICKS_PER_SEC - 1)) begin
        tick      = 1'b1;
        presc_nxt = '0;
      end else begin
        presc_nxt = presc + 1'b1;
      end
    end

    if (tick) begin
      if (sec_r == 7'd59) begin
        sec_nxt = 7'd0;
        if (min_r == 7'(MAX_MINUTES)) begin
          min_nxt = 7'd0;
          wrap    = 1'b1;
        end else begin
          min_nxt = min_r + 7'd1;
        end
      end else begin
        sec_nxt = sec_r + 7'd1;
      end
    end

    // A tick coinciding with start_stop is still applied; only the state toggles.
    if (start_stop) begin
      case (state)
        IDLE, PAUSED: state_nxt = RUNNING;
        RUNNING:      state_nxt = PAUSED;
        default:      state_nxt = IDLE;
      endcase
    end

    if (clear) begin
      state_nxt = IDLE;
      presc_nxt = '0;
      min_nxt   = 7'd0;
      sec_nxt   = 7'd0;
      wrap      = 1'b0;
    end
  end

`ifdef LAP_HOLD_EN
  // Any lap releases an engaged hold; a new hold can only be engaged while running.
  always_comb begin
    hold_nxt = hold_active;
    if (clear) begin
      hold_nxt = 1'b0;
    end else if (lap) begin
      if (hold_active)
        hold_nxt = 1'b0;
      else if (state == RUNNING)
        hold_nxt = 1'b1;
    end
  end
`else
  assign hold_nxt = lap & 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      presc       <= '0;
      min_r       <= 7'd0;
      sec_r       <= 7'd0;
      minutes     <= 7'd0;
      seconds     <= 7'd0;
      running     <= 1'b0;
      rollover    <= 1'b0;
      hold_active <= 1'b0;
    end else begin
      state       <= state_nxt;
      presc       <= presc_nxt;
      min_r       <= min_nxt;
      sec_r       <= sec_nxt;
      running     <= (state_nxt == RUNNING);
      rollover    <= wrap;
      hold_active <= hold_nxt;
      // Display loads the post-edge time, so live outputs never lag the internal counters.
      if (!hold_nxt) begin
        minutes <= min_nxt;
        seconds <= sec_nxt;
      end
    end
  end

endmodule

// File: tb/tb_stopwatch_timer_core.sv
// Bench for stopwatch_timer_core: directed scenarios plus random pulses against an elapsed-cycle model.
module tb_stopwatch_timer_core;

  localparam int     T      = 4;
  localparam int     MAXM   = 99;
  localparam longint PERIOD = longint'(MAXM + 1) * 60;

  logic       clock = 1'b0;
  logic       reset, start_stop, clear, lap;
  logic [6:0] minutes, seconds;
  logic       running, rollover, hold_active;

  int n_cmp = 0;
  int n_bad = 0;
  int roll_cnt = 0;

  stopwatch_timer_core #(
    .TICKS_PER_SEC(T),
    .PRESC_W(3),
    .MAX_MINUTES(MAXM)
  ) dut (
    .clock(clock),
    .reset(reset),
    .start_stop(start_stop),
    .clear(clear),
    .lap(lap),
    .minutes(minutes),
    .seconds(seconds),
    .running(running),
    .rollover(rollover),
    .hold_active(hold_active)
  );

  always #5 clock = ~clock;

  // Model: total cycles spent running; time and prescaler fall out by division.
  int     m_st;   // 0 idle, 1 running, 2 paused
  longint m_el;
  bit     m_hold, m_roll;
  int     m_dmin, m_dsec;

  function automatic longint total_sec();
    return m_el / T;
  endfunction

  function automatic int live_sec();
    return int'(total_sec() % 60);
  endfunction

  function automatic int live_min();
    return int'((total_sec() / 60) % (MAXM + 1));
  endfunction

  task automatic model_reset();
    m_st = 0; m_el = 0; m_hold = 0; m_roll = 0; m_dmin = 0; m_dsec = 0;
  endtask

  task automatic model_edge(input bit ss, input bit clr, input bit lp);
    bit tick;
    bit hold_n;
    if (clr) begin
      model_reset();
      return;
    end
    tick = 0;
    if (m_st == 1) begin
      m_el++;
      tick = (m_el % T) == 0;
    end
    m_roll = tick && ((total_sec() % PERIOD) == 0);
    hold_n = m_hold;
`ifdef LAP_HOLD_EN
    if (lp) begin
      if (m_hold) hold_n = 0;
      else if (m_st == 1) hold_n = 1;
    end
`else
    if (lp) hold_n = 0;
`endif
    if (ss) m_st = (m_st == 1) ? 2 : 1;
    m_hold = hold_n;
    if (!m_hold) begin
      m_dmin = live_min();
      m_dsec = live_sec();
    end
  endtask

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    check_eq("minutes", int'(minutes), m_dmin);
    check_eq("seconds", int'(seconds), m_dsec);
    check_eq("running", int'(running), (m_st == 1) ? 1 : 0);
    check_eq("rollover", int'(rollover), int'(m_roll));
    check_eq("hold_active", int'(hold_active), int'(m_hold));
  endtask

  task automatic step(input bit ss, input bit clr, input bit lp);
    start_stop = ss; clear = clr; lap = lp;
    @(posedge clock);
    model_edge(ss, clr, lp);
    #1;
    start_stop = 0; clear = 0; lap = 0;
    if (rollover === 1'b1) roll_cnt++;
    check_all();
  endtask

  task automatic run_to_sec(input longint s);
    longint budget;
    budget = (s - total_sec() + 1) * T + 8;
    while (total_sec() < s && budget > 0) begin
      step(0, 0, 0);
      budget--;
    end
    check_eq("run_to_sec_reached", int'(total_sec() >= s), 1);
  endtask

  initial begin
    reset = 1; start_stop = 0; clear = 0; lap = 0;
    model_reset();
    #12;
    check_all();
    @(negedge clock);
    reset = 0;

    // Start timing: seconds step at start+4 and start+8.
    step(0, 0, 0);
    step(1, 0, 0);
    check_eq("running_after_start", int'(running), 1);
    repeat (8) step(0, 0, 0);
    check_eq("seconds_after_8", int'(seconds), 2);

    // Pause two cycles into a second, hold 20 cycles, resume.
    repeat (2) step(0, 0, 0);
    step(1, 0, 0);
    repeat (20) step(0, 0, 0);
    check_eq("seconds_paused", int'(seconds), 2);
    step(1, 0, 0);
    repeat (2) step(0, 0, 0);
    check_eq("seconds_after_resume", int'(seconds), 3);

    // Full run 00:00 -> 00:59 -> 01:00 -> 99:59 -> 00:00.
    step(0, 1, 0);
    step(1, 0, 0);
    roll_cnt = 0;
    run_to_sec(59);
    run_to_sec(60);
    check_eq("min_at_60s", int'(minutes), 1);
    check_eq("sec_at_60s", int'(seconds), 0);
    run_to_sec(PERIOD - 1);
    check_eq("min_at_9959", int'(minutes), MAXM);
    run_to_sec(PERIOD);
    check_eq("rollover_at_wrap", int'(rollover), 1);
    step(0, 0, 0);
    check_eq("rollover_one_cycle", int'(rollover), 0);
    check_eq("running_after_wrap", int'(running), 1);
    check_eq("rollover_count", roll_cnt, 1);

    // clear + start_stop together at 03:15.
    run_to_sec(PERIOD + 195);
    step(0, 0, 0);
    step(1, 1, 0);
    check_eq("clear_min", int'(minutes), 0);
    check_eq("clear_sec", int'(seconds), 0);
    check_eq("clear_running", int'(running), 0);
    repeat (6) step(0, 0, 0);

    // Lap hold at 00:05 until internal 00:09.
    step(1, 0, 0);
    run_to_sec(5);
    step(0, 0, 0);
    step(0, 0, 1);
    run_to_sec(9);
    step(0, 0, 0);
    step(0, 0, 1);
    check_eq("lap_release_sec", int'(seconds), 9);
    repeat (4) step(0, 0, 0);

    // Asynchronous reset mid-count at 00:07.
    step(0, 1, 0);
    step(1, 0, 0);
    run_to_sec(7);
    step(0, 0, 0);
    #3;
    reset = 1;
    #1;
    model_reset();
    check_all();
    @(negedge clock);
    reset = 0;
    repeat (6) step(0, 0, 0);

    // Random pulse traffic.
    for (int i = 0; i < 4000; i++) begin
      int r;
      r = $urandom_range(0, 199);
      step(r < 6, r == 6, (r >= 7) && (r < 13));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
